// File: rtl/barrel_rotl_pipe.sv
// -----------------------------------------------------------------------------
// barrel_rotl_pipe
//
// Purpose:
//   Pipelined left rotator with a valid/ready handshake. It computes
//   o_y = i_a rotated left by i_k and undoes the combinational right-rotating
//   barrel_shifter, so rotl(rotr(a, k), k) == a. It sits on the receive/decode
//   side of the rotate datapath, between buffered blocks.
//
//   There are SHW stages. Stage s rotates by 2**(SHW-1-s) when bit SHW-1-s
//   of the carried shift amount is set. Stage 0 uses the largest step and the
//   last stage uses a step of 1. Each stage registers its rotated data, the
//   shift amount and a valid bit. The last stage's registers drive o_y and
//   o_valid directly.
//
//   Any stage that is empty, or whose successor is advancing, loads a new
//   value. Bubbles therefore collapse even when the output is stalled.
//   o_ready is the head of that combinational advance chain.
//
// Parameters:
//   WIDTH  data width; must equal 2**SHW.
//   SHW    shift-amount width; also the number of pipeline stages.
//
// Ports:
//   i_clk    in   1      clock, rising edge
//   i_rst    in   1      synchronous active-high reset
//   i_valid  in   1      upstream word valid
//   o_ready  out  1      block accepts a word this cycle
//   i_a      in   WIDTH  data word
//   i_k      in   SHW    rotate amount, 0..WIDTH-1
//   i_dir    in   1      (BARREL_ROTL_BIDIR_EN only) 0 = rotate left,
//                        1 = rotate right
//   o_valid  out  1      o_y holds a result
//   i_ready  in   1      downstream accepts o_y this cycle
//   o_y      out  WIDTH  rotated result
//
// Optional feature macro: BARREL_ROTL_BIDIR_EN
//   When this macro is defined, the block gains an i_dir input. i_dir is
//   sampled with i_a and carried through every stage. A 1 selects a right
//   rotate, o_y[i] = i_a[(i + k) mod WIDTH]. Latency and handshake are the
//   same in both directions.
// -----------------------------------------------------------------------------
module barrel_rotl_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SHW-1:0]   i_k,
`ifdef BARREL_ROTL_BIDIR_EN
  input  logic             i_dir,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y
);

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]            v_q, v_d;
  logic [SHW-1:0][WIDTH-1:0] d_q, d_d;
  logic [SHW-1:0][SHW-1:0]   k_q, k_d;
`ifdef BARREL_ROTL_BIDIR_EN
  logic [SHW-1:0]            dir_q, dir_d;
`endif

  // Per-stage inputs: the block's input port for stage 0, otherwise the
  // preceding stage's registers.
  logic [SHW-1:0]            in_v;
  logic [SHW-1:0][WIDTH-1:0] in_d;
  logic [SHW-1:0][SHW-1:0]   in_k;
`ifdef BARREL_ROTL_BIDIR_EN
  logic [SHW-1:0]            in_dir;
`endif

  // Rotated data that each stage would load on its next advance.
  logic [SHW-1:0][WIDTH-1:0] rot_d;

  // adv[s]: stage s loads at the next edge.
  logic [SHW-1:0]            adv;

  // ---------------------------------------------------------------------------
  // Per-stage datapath: input selection and a 2:1 pass/rotate mux
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
    // Stage gi handles shift-amount bit SEL, which has weight AMT.
    localparam int SEL = SHW - 1 - gi;
    localparam int AMT = 1 << SEL;

    if (gi == 0) begin : g_head
      assign in_v[gi] = i_valid;
      assign in_d[gi] = i_a;
      assign in_k[gi] = i_k;
`ifdef BARREL_ROTL_BIDIR_EN
      assign in_dir[gi] = i_dir;
`endif
    end else begin : g_link
      assign in_v[gi] = v_q[gi-1];
      assign in_d[gi] = d_q[gi-1];
      assign in_k[gi] = k_q[gi-1];
`ifdef BARREL_ROTL_BIDIR_EN
      assign in_dir[gi] = dir_q[gi-1];
`endif
    end

    // AMT never exceeds WIDTH/2, so WIDTH-AMT is always a legal shift.
    logic [WIDTH-1:0] rotl_w;
    assign rotl_w = (in_d[gi] << AMT) | (in_d[gi] >> (WIDTH - AMT));

`ifdef BARREL_ROTL_BIDIR_EN
    logic [WIDTH-1:0] rotr_w;
    assign rotr_w = (in_d[gi] >> AMT) | (in_d[gi] << (WIDTH - AMT));
    assign rot_d[gi] = !in_k[gi][SEL] ? in_d[gi]
                     : (in_dir[gi] ? rotr_w : rotl_w);
`else
    assign rot_d[gi] = in_k[gi][SEL] ? rotl_w : in_d[gi];
`endif
  end

  // ---------------------------------------------------------------------------
  // Advance chain, built from the output back toward the input.
  // A stage may load when it is empty or its successor is moving.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic chain;
    chain = i_ready;
    adv   = '0;
    for (int s = SHW - 1; s >= 0; s--) begin
      chain  = ~v_q[s] | chain;
      adv[s] = chain;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: advancing stages load from their inputs; others hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    k_d = k_q;
`ifdef BARREL_ROTL_BIDIR_EN
    dir_d = dir_q;
`endif
    for (int s = 0; s < SHW; s++) begin
      if (adv[s]) begin
        v_d[s] = in_v[s];
        d_d[s] = rot_d[s];
        k_d[s] = in_k[s];
`ifdef BARREL_ROTL_BIDIR_EN
        dir_d[s] = in_dir[s];
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q <= '0;
      d_q <= '0;
      k_q <= '0;
`ifdef BARREL_ROTL_BIDIR_EN
      dir_q <= '0;
`endif
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      k_q <= k_d;
`ifdef BARREL_ROTL_BIDIR_EN
      dir_q <= dir_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_ready = adv[0];
  assign o_valid = v_q[SHW-1];
  assign o_y     = d_q[SHW-1];

  // The last stage's shift amount (and direction) have no further consumer.
  // They are kept so that every stage has the same shape.
  logic unused_tail;
`ifdef BARREL_ROTL_BIDIR_EN
  assign unused_tail = ^{k_q[SHW-1], dir_q[SHW-1]};
`else
  assign unused_tail = ^k_q[SHW-1];
`endif

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
module tb_barrel_rotl_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] i_a = '0;
  logic [SHW-1:0]   i_k = '0;
`ifdef BARREL_ROTL_BIDIR_EN
  logic             i_dir = 1'b0;
`endif
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_y;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  barrel_rotl_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_k     (i_k),
`ifdef BARREL_ROTL_BIDIR_EN
    .i_dir   (i_dir),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y)
  );

  // Reference model: bit i of a left rotate takes bit (i - k) mod W.
  function automatic logic [WIDTH-1:0] rotl_ref(input logic [WIDTH-1:0] a, input int k);
    logic [WIDTH-1:0] y;
    for (int i = 0; i < WIDTH; i++) y[i] = a[(i - k + WIDTH) % WIDTH];
    return y;
  endfunction

  // Forward (right-rotating) barrel shifter: bit i takes bit (i + k) mod W.
  function automatic logic [WIDTH-1:0] rotr_ref(input logic [WIDTH-1:0] a, input int k);
    logic [WIDTH-1:0] y;
    for (int i = 0; i < WIDTH; i++) y[i] = a[(i + k) % WIDTH];
    return y;
  endfunction

  // One clock cycle. Inputs are driven 1 ns after a rising edge, and
  // observations are taken 1 ns later, before the next edge.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] a, input logic [SHW-1:0] k,
                     input logic r, output logic acc, output logic fire,
                     output logic ov, output logic [WIDTH-1:0] y, output logic rdy);
    i_valid = v;
    i_a     = a;
    i_k     = k;
    i_ready = r;
    #1;
    rdy  = o_ready;
    acc  = v & o_ready;
    ov   = o_valid;
    y    = o_y;
    fire = o_valid & r;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_a = 8'hFF; i_k = 3'd5; i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    n_vec++; if (o_y !== 8'h00) begin n_err++; $display("FAIL reset_o_y: got %h expected 00", o_y); end
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_o_ready: got %b expected 1", o_ready); end
    $display("reset: o_valid=%b o_y=%h o_ready=%b", o_valid, o_y, o_ready);
  endtask

  task automatic test_single();
    logic acc, fire, ov, rdy;
    logic [WIDTH-1:0] y;
    cyc(1'b1, 8'h01, 3'd3, 1'b1, acc, fire, ov, y, rdy);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b expected 1", acc); end
    for (int c = 1; c <= 4; c++) begin
      cyc(1'b0, 8'h00, 3'd0, 1'b1, acc, fire, ov, y, rdy);
      n_vec++; if (ov !== (c == 3)) begin n_err++; $display("FAIL single_latency c=%0d: o_valid got %b expected %b", c, ov, (c == 3)); end
      n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL single_ready c=%0d: got %b expected 1", c, rdy); end
      if (c == 3) begin
        n_vec++; if (y !== 8'h08) begin n_err++; $display("FAIL single_data: got %h expected 08", y); end
        $display("single: a=01 k=3 -> y=%h", y);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, fire, ov, rdy;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] a_t [4];
    logic [SHW-1:0]   k_t [4];
    logic [WIDTH-1:0] e_t [4];
    a_t = '{8'h96, 8'hA5, 8'h3C, 8'h80};
    k_t = '{3'd1, 3'd4, 3'd0, 3'd7};
    e_t = '{8'h2D, 8'h5A, 8'h3C, 8'h40};
    for (int c = 0; c < 9; c++) begin
      if (c < 4) cyc(1'b1, a_t[c], k_t[c], 1'b1, acc, fire, ov, y, rdy);
      else       cyc(1'b0, 8'h00, 3'd0, 1'b1, acc, fire, ov, y, rdy);
      if (c < 4) begin
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_accept c=%0d: got %b expected 1", c, acc); end
      end
      n_vec++; if (ov !== (c >= 3 && c <= 6)) begin n_err++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, ov, (c >= 3 && c <= 6)); end
      if (c >= 3 && c <= 6) begin
        n_vec++; if (y !== e_t[c-3]) begin n_err++; $display("FAIL b2b_data c=%0d: got %h expected %h", c, y, e_t[c-3]); end
        $display("b2b: out c=%0d y=%h", c, y);
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, fire, ov, rdy;
    logic [WIDTH-1:0] y, cur_a, first_exp;
    logic [SHW-1:0]   cur_k;
    logic [WIDTH-1:0] w [5];
    logic [SHW-1:0]   kk [5];
    int idx, outcnt;
    for (int i = 0; i < 5; i++) begin
      w[i]  = 8'($urandom);
      kk[i] = 3'($urandom);
    end
    first_exp = rotl_ref(w[0], int'(kk[0]));
    idx = 0;
    // Stalled output: three words fill the pipe, then o_ready drops.
    for (int c = 0; c < 8; c++) begin
      cur_a = w[idx]; cur_k = kk[idx];
      cyc(1'b1, cur_a, cur_k, 1'b0, acc, fire, ov, y, rdy);
      if (acc) idx++;
      n_vec++; if (acc !== (c < 3)) begin n_err++; $display("FAIL bp_accept c=%0d: got %b expected %b", c, acc, (c < 3)); end
      if (c >= 3) begin
        n_vec++; if (ov !== 1'b1 || y !== first_exp) begin n_err++; $display("FAIL bp_hold c=%0d: got v=%b y=%h expected v=1 y=%h", c, ov, y, first_exp); end
      end
    end
    // Release: all five words must leave in order.
    outcnt = 0;
    for (int c = 0; c < 40 && outcnt < 5; c++) begin
      cur_a = (idx < 5) ? w[idx] : 8'h00;
      cur_k = (idx < 5) ? kk[idx] : 3'd0;
      cyc(idx < 5, cur_a, cur_k, 1'b1, acc, fire, ov, y, rdy);
      if (acc) idx++;
      if (fire) begin
        n_vec++; if (y !== rotl_ref(w[outcnt], int'(kk[outcnt]))) begin n_err++; $display("FAIL bp_drain #%0d: got %h expected %h", outcnt, y, rotl_ref(w[outcnt], int'(kk[outcnt]))); end
        $display("bp: out #%0d y=%h", outcnt, y);
        outcnt++;
      end
    end
    n_vec++; if (outcnt !== 5) begin n_err++; $display("FAIL bp_count: got %0d outputs expected 5", outcnt); end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 8'h00, 3'd0, 1'b1, acc, fire, ov, y, rdy);
      n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL bp_no_dup c=%0d: o_valid got %b expected 0", c, ov); end
    end
  endtask

  task automatic test_reset_mid();
    logic acc, fire, ov, rdy;
    logic [WIDTH-1:0] y;
    cyc(1'b1, 8'h5A, 3'd2, 1'b1, acc, fire, ov, y, rdy);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rstmid_accept0: got %b expected 1", acc); end
    cyc(1'b1, 8'hC3, 3'd5, 1'b1, acc, fire, ov, y, rdy);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL rstmid_accept1: got %b expected 1", acc); end
    i_rst = 1'b1;
    cyc(1'b0, 8'h00, 3'd0, 1'b1, acc, fire, ov, y, rdy);
    i_rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 8'h00, 3'd0, 1'b1, acc, fire, ov, y, rdy);
      n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL rstmid_valid c=%0d: got %b expected 0", c, ov); end
      if (c == 0) begin
        n_vec++; if (y !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h expected 00", y); end
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", rdy); end
      end
    end
    $display("reset_mid: in-flight words discarded");
  endtask

  task automatic test_round_trip();
    logic acc, fire, ov, rdy, v, r;
    logic [WIDTH-1:0] y, a, fin, e;
    logic [SHW-1:0]   k;
    logic [WIDTH-1:0] exp_q [$];
    int send, got;
    localparam int TOTAL = 256 * 8;
    send = 0; got = 0;
    for (int c = 0; c < 20000 && got < TOTAL; c++) begin
      a   = send[7:0];
      k   = send[10:8];
      fin = rotr_ref(a, int'(k));
      v   = (send < TOTAL) && ($urandom_range(3) != 0);
      r   = ($urandom_range(3) != 0);
      cyc(v, fin, k, r, acc, fire, ov, y, rdy);
      if (acc) begin
        exp_q.push_back(a);
        send++;
      end
      if (fire) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rt_spurious: got output %h expected none", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin n_err++; $display("FAIL rt_data #%0d: got %h expected %h", got, y, e); end
        end
        got++;
      end
    end
    n_vec++; if (got !== TOTAL) begin n_err++; $display("FAIL rt_count: got %0d outputs expected %0d", got, TOTAL); end
    $display("round_trip: %0d words returned", got);
  endtask

`ifdef BARREL_ROTL_BIDIR_EN
  task automatic test_bidir();
    logic acc, fire, ov, rdy;
    logic [WIDTH-1:0] y;
    for (int c = 0; c < 7; c++) begin
      i_dir = (c == 0);
      if (c < 2) cyc(1'b1, 8'h01, 3'd1, 1'b1, acc, fire, ov, y, rdy);
      else       cyc(1'b0, 8'h00, 3'd0, 1'b1, acc, fire, ov, y, rdy);
      if (c == 3) begin
        n_vec++; if (ov !== 1'b1 || y !== 8'h80) begin n_err++; $display("FAIL bidir_right: got v=%b y=%h expected v=1 y=80", ov, y); end
      end
      if (c == 4) begin
        n_vec++; if (ov !== 1'b1 || y !== 8'h02) begin n_err++; $display("FAIL bidir_left: got v=%b y=%h expected v=1 y=02", ov, y); end
      end
    end
    i_dir = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
`ifdef BARREL_ROTL_BIDIR_EN
    test_bidir();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/barrel_rotl_pipe.md
Name: barrel_rotl_pipe

Overview:
- Pipelined left rotator: o_y = i_a rotated left by i_k.
- Inverse of the team's combinational right-rotating barrel_shifter, so rotl(rotr(a,k),k) = a.
- Sits on the receive/decode side of the rotate datapath.
- Adds registered stages and a valid/ready handshake so it can sit between buffered blocks.

Parameters:
- WIDTH, 8, data width; must equal 2**SHW.
- SHW, 3, shift-amount width; also the number of pipeline stages.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word this cycle.
- i_a  input  WIDTH  data word.
- i_k  input  SHW  left-rotate amount, 0..WIDTH-1.
- o_valid  output  1  o_y holds a result.
- i_ready  input  1  downstream accepts o_y this cycle.
- o_y  output  WIDTH  rotated result, rotate-left of i_a by i_k.

Behaviour:
- Function: o_y[i] = i_a[(i - k) mod WIDTH] for each bit i, using unsigned modular indexing.
- Stage structure: SHW stages, each with registers v[s], d[s], k[s].
  - Stage 0 rotates left by 2**(SHW-1) when k[SHW-1]=1.
  - Each following stage uses the next lower bit.
  - Stage SHW-1 rotates by 1 when k[0]=1.
  - Each stage is a 2:1 mux per bit: pass or rotate.
- Stage contents: each stage registers its rotated data plus the remaining k bits and a valid bit. o_y and o_valid are the last stage's registers.
- Advance rule:
  - adv[SHW-1] = !v[SHW-1] | i_ready.
  - adv[s] = !v[s] | adv[s+1].
  - o_ready = adv[0], a combinational chain.
- Accept and latency:
  - A word is accepted when i_valid & o_ready.
  - With no stalls, it appears at o_valid exactly SHW cycles after acceptance (3 for defaults).
  - Full throughput: one word per cycle.
- Bubble collapse: an empty stage loads even if downstream stalls, so bubbles are squeezed out under backpressure.
- Stall hold: while o_valid=1 and i_ready=0, o_y is stable and must not change. Stalled stages hold d/k/v unchanged.
- Full pipeline: with all v=1 and i_ready=0, o_ready=0; i_valid is ignored and no data is lost.
- Simultaneous events: in the same cycle, the output drains (i_ready=1) and a new word is accepted, with no gap.
- Boundary values:
  - k=0 passes data through unchanged, same latency.
  - k=WIDTH-1 equals rotate-right by 1.
  - Out-of-range k cannot occur because SHW bits exactly span 0..WIDTH-1.
- Reset: when i_rst=1 at a clock edge, the following clear.
  - All v to 0, all d and k to 0.
  - o_valid=0, o_y=0.
  - o_ready is 1 in the first cycle after reset release.
- Reset mid-operation: in-flight words are discarded and not output after reset.

Optional Feature:
- Macro: BARREL_ROTL_BIDIR_EN.
- Defined:
  - Adds input port i_dir (1 bit), sampled with i_a and carried through the stages.
  - i_dir=0 gives a left rotate. i_dir=1 gives a right rotate, o_y[i] = i_a[(i + k) mod WIDTH], matching the forward barrel_shifter.
  - Latency and handshake are unchanged. i_dir resets to 0 in all stages.
- Undefined: no i_dir port, left rotate only.

Test Plan:
1. Single word: reset, then i_a=0x01, i_k=3, i_ready=1 -> o_y=0x08 with o_valid high exactly 3 cycles after acceptance, o_ready=1 throughout.
2. Back-to-back: stream (0x96,k=1), (0xA5,k=4), (0x3C,k=0), (0x80,k=7) on consecutive cycles -> outputs 0x2D, 0x5A, 0x3C, 0x40 on 4 consecutive cycles starting cycle 3.
3. Backpressure:
   - Feed 5 words continuously with i_ready=0 -> o_ready drops after the 3rd accept.
   - o_y holds the first result stable.
   - Raise i_ready -> all 5 results exit in order, none dropped or duplicated.
4. Reset mid-operation: accept 2 words, assert i_rst for 1 cycle -> o_valid=0 and o_y=0 on the next cycle, and neither word ever appears.
5. Round trip: drive all 256 values × 8 k through a forward right rotate into this block -> o_y equals the original i_a for every case, random i_valid/i_ready gaps.
6. With BARREL_ROTL_BIDIR_EN: i_a=0x01, k=1, i_dir=1 -> o_y=0x80; i_dir=0 -> o_y=0x02.
